// File: rtl/gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_pkg.sv
// Shared definitions for the cell self-test sequencer: FSM states, the counter
// width helper and reference truth tables for common 9-track cells.
package gf180mcu_fd_sc_mcu9t5v0__selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    function automatic int settle_cnt_w(int settle);
        return (settle < 1) ? 1 : $clog2(settle + 1);
    endfunction

    // Bit v is the expected ZN when the cell inputs carry vector v.
    localparam logic [3:0] TRUTH_NOR2  = 4'b0001;
    localparam logic [7:0] TRUTH_NOR3  = 8'b0000_0001;
    localparam logic [7:0] TRUTH_NAND3 = 8'b0111_1111;
    localparam logic [7:0] TRUTH_OR3   = 8'b1111_1110;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_if.sv
// Harness-facing bundle of the sequencer: control, cell stimulus/response and results.
interface gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_if #(
    parameter int N_IN = 3
);
    logic            START;
    logic            ABORT;
    logic            ZN_IN;
    logic [N_IN-1:0] STIM;
    logic            BUSY;
    logic            DONE;
    logic            PASS;
    logic [N_IN:0]   ERR_CNT;
    logic            FAIL_VALID;
    logic [N_IN-1:0] FIRST_FAIL;

    // master: harness plus cell under test; slave: the sequencer itself.
    modport master (
        output START, ABORT, ZN_IN,
        input  STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FIRST_FAIL
    );

    modport slave (
        input  START, ABORT, ZN_IN,
        output STIM, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FIRST_FAIL
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_settle_cnt.sv
// Loadable down-counter timing the settle window; tc_o is high once the count reaches zero.
module gf180mcu_fd_sc_mcu9t5v0__settle_cnt #(
    parameter int W = 2
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments; RN is synchronous so it only acts at a clock edge.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq.sv
// Self-test sequencer: sweeps every input vector of a combinational cell, samples ZN
// after SETTLE idle cycles and accumulates mismatches against the TRUTH table.
module gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq
    import gf180mcu_fd_sc_mcu9t5v0__selftest_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2,
    parameter     TRUTH  = TRUTH_NOR3
) (
    input logic CLK,
    input logic RN,
    gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_if.slave bus
);

    localparam int NV    = 2 ** N_IN;
    localparam int ERR_W = N_IN + 1;
    localparam int CW    = settle_cnt_w(SETTLE);

    localparam logic [NV-1:0] TRUTH_VEC = TRUTH;
    // The counter is reloaded on the apply edge, so SETTLE-1 more edges elapse before SAMPLE.
    localparam logic [CW-1:0] CNT_LOAD  = CW'(SETTLE - 1);

    if (N_IN < 1 || N_IN > 6) begin : g_bad_n_in
        $error("N_IN must be in 1..6");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("SETTLE must be at least 1");
    end
    if ($bits(TRUTH) != NV) begin : g_bad_truth
        $error("TRUTH must be 2**N_IN bits wide");
    end

    state_e state_q, state_d;

    logic [N_IN-1:0]  stim_q;
    logic             busy_q, done_q, pass_q, fail_valid_q;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [N_IN-1:0]  first_fail_q;

    logic idle_like, last_vec, tc, mismatch;
    logic start_ok, cnt_dec, do_sample, cnt_load;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign last_vec  = (stim_q == '1);
    assign mismatch  = (bus.ZN_IN != TRUTH_VEC[stim_q]);
    assign err_cnt_d = err_cnt_q + ERR_W'(mismatch);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (bus.START) state_d = ST_SETTLE;
                ST_SETTLE:        if (tc) state_d = ST_SAMPLE;
                ST_SAMPLE:        state_d = last_vec ? ST_DONE : ST_SETTLE;
                default:          state_d = ST_IDLE;
            endcase
        end
    end

    // ABORT dominates every other action, including a coincident START.
    always_comb begin
        start_ok  = 1'b0;
        cnt_dec   = 1'b0;
        do_sample = 1'b0;
        if (!bus.ABORT) begin
            start_ok  = idle_like && bus.START;
            cnt_dec   = (state_q == ST_SETTLE) && !tc;
            do_sample = (state_q == ST_SAMPLE);
        end
    end

    assign cnt_load = start_ok || do_sample;

    gf180mcu_fd_sc_mcu9t5v0__settle_cnt #(.W(CW)) u_settle_cnt (
        .CLK       (CLK),
        .RN        (RN),
        .load_i    (cnt_load),
        .load_val_i(CNT_LOAD),
        .dec_i     (cnt_dec),
        .tc_o      (tc)
    );

    always_ff @(posedge CLK) begin
        if (!RN) begin
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else if (bus.ABORT) begin
            // Partial error results stay visible for post-mortem after an abort.
            stim_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (start_ok) begin
            stim_q       <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else if (do_sample) begin
            err_cnt_q <= err_cnt_d;
            pass_q    <= (err_cnt_d == '0);
            if (mismatch && !fail_valid_q) begin
                first_fail_q <= stim_q;
                fail_valid_q <= 1'b1;
            end
            if (last_vec) begin
                stim_q <= '0;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end else begin
                stim_q <= stim_q + N_IN'(1);
            end
        end
    end

    assign bus.STIM       = stim_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PASS       = pass_q;
    assign bus.ERR_CNT    = err_cnt_q;
    assign bus.FAIL_VALID = fail_valid_q;
    assign bus.FIRST_FAIL = first_fail_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq.sv
// Bench for the cell self-test sequencer: a sweep-level reference model checked every
// cycle against the default (NOR3) instance, plus a small NAND2 instance checked directly.
module tb_gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq;
    import gf180mcu_fd_sc_mcu9t5v0__selftest_pkg::*;

    localparam int P0  = 3;   // SETTLE+1 of the default instance
    localparam int NV0 = 8;

    logic clk = 1'b0;
    logic rn  = 1'b0;
    int   mode0 = 0;   // 0 NOR3, 1 stuck-1, 2 stuck-0, 3 OR3, 4 NAND3
    int   mode1 = 0;   // 0 NAND2, 1 stuck-0
    bit   cmp_en = 1'b0;
    int   n_vec = 0;
    int   n_mis = 0;

    gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_if #(.N_IN(3)) bus0 ();
    gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq_if #(.N_IN(2)) bus1 ();

    gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq dut0 (
        .CLK(clk),
        .RN (rn),
        .bus(bus0)
    );

    gf180mcu_fd_sc_mcu9t5v0__comb_vec_seq #(.N_IN(2), .SETTLE(1), .TRUTH(4'b0111)) dut1 (
        .CLK(clk),
        .RN (rn),
        .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic logic cell3(int mode, logic [2:0] v);
        case (mode)
            0:       return ~|v;
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return |v;
            default: return ~&v;
        endcase
    endfunction

    function automatic logic cell2(int mode, logic [1:0] v);
        return (mode == 0) ? ~&v : 1'b0;
    endfunction

    assign bus0.ZN_IN = cell3(mode0, bus0.STIM);
    assign bus1.ZN_IN = cell2(mode1, bus1.STIM);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sweep-level model: k counts edges since the accepted START; every P0-th edge samples vector k/P0-1.
    bit         m_run  = 1'b0;
    int         m_k    = 0;
    int         m_stim = 0;
    bit         m_done = 1'b0;
    bit         m_pass = 1'b0;
    bit         m_fv   = 1'b0;
    int         m_err  = 0;
    int         m_ff   = 0;
    int         m_v;

    always @(posedge clk) begin
        if (!rn) begin
            m_run = 0; m_done = 0; m_pass = 0; m_fv = 0; m_err = 0; m_ff = 0;
        end else if (bus0.ABORT) begin
            m_run = 0; m_done = 0; m_pass = 0;
        end else if (bus0.START && !m_run) begin
            m_run = 1; m_k = 0; m_done = 0; m_pass = 0; m_fv = 0; m_err = 0; m_ff = 0;
        end else if (m_run) begin
            m_k++;
            if (m_k % P0 == 0) begin
                m_v = m_k / P0 - 1;
                if (cell3(mode0, 3'(m_v)) != (m_v == 0)) begin
                    m_err++;
                    if (!m_fv) begin
                        m_fv = 1;
                        m_ff = m_v;
                    end
                end
                m_pass = (m_err == 0);
                if (m_v == NV0 - 1) begin
                    m_run  = 0;
                    m_done = 1;
                end
            end
        end
        m_stim = m_run ? m_k / P0 : 0;
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("STIM",       bus0.STIM,       m_stim);
                check("BUSY",       bus0.BUSY,       m_run);
                check("DONE",       bus0.DONE,       m_done);
                check("PASS",       bus0.PASS,       m_pass);
                check("ERR_CNT",    bus0.ERR_CNT,    m_err);
                check("FAIL_VALID", bus0.FAIL_VALID, m_fv);
                check("FIRST_FAIL", bus0.FIRST_FAIL, m_ff);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start0();
        bus0.START = 1'b1;
        cyc(1);
        bus0.START = 1'b0;
    endtask

    // Full sweep on dut0 with hand-computed final results; DONE must rise exactly at e0+24.
    task automatic sweep0(input string tag, input int err, input int ff, input bit fv, input bit pass);
        pulse_start0();
        cyc(23);
        check({tag, "_done_early"}, bus0.DONE, 1'b0);
        cyc(1);
        check({tag, "_done"},   bus0.DONE,       1'b1);
        check({tag, "_busy"},   bus0.BUSY,       1'b0);
        check({tag, "_stim"},   bus0.STIM,       3'd0);
        check({tag, "_err"},    bus0.ERR_CNT,    err);
        check({tag, "_ff"},     bus0.FIRST_FAIL, ff);
        check({tag, "_fv"},     bus0.FAIL_VALID, fv);
        check({tag, "_pass"},   bus0.PASS,       pass);
        check({tag, "_model"},  m_err,           err);
    endtask

    task automatic sweep1(input string tag, input int err, input int ff, input bit fv, input bit pass);
        bus1.START = 1'b1;
        cyc(1);
        bus1.START = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check({tag, "_stim"}, bus1.STIM, k / 2);
            check({tag, "_done_early"}, bus1.DONE, 1'b0);
            cyc(1);
        end
        check({tag, "_done"}, bus1.DONE,       1'b1);
        check({tag, "_err"},  bus1.ERR_CNT,    err);
        check({tag, "_ff"},   bus1.FIRST_FAIL, ff);
        check({tag, "_fv"},   bus1.FAIL_VALID, fv);
        check({tag, "_pass"}, bus1.PASS,       pass);
    endtask

    initial begin : main
        bus0.START = 1'b0; bus0.ABORT = 1'b0;
        bus1.START = 1'b0; bus1.ABORT = 1'b0;
        rn = 1'b0;
        cyc(3);
        check("rst_stim",  bus0.STIM,       3'd0);
        check("rst_busy",  bus0.BUSY,       1'b0);
        check("rst_done",  bus0.DONE,       1'b0);
        check("rst_pass",  bus0.PASS,       1'b0);
        check("rst_err",   bus0.ERR_CNT,    4'd0);
        check("rst_fv",    bus0.FAIL_VALID, 1'b0);
        check("rst_ff",    bus0.FIRST_FAIL, 3'd0);
        check("rst1_busy", bus1.BUSY,       1'b0);
        check("rst1_done", bus1.DONE,       1'b0);
        rn = 1'b1;
        cmp_en = 1'b1;

        mode0 = 0; sweep0("nor3",   0, 0, 0, 1);
        mode0 = 1; sweep0("stuck1", 7, 1, 1, 0);
        mode0 = 2; sweep0("stuck0", 1, 0, 1, 0);
        mode0 = 3; sweep0("or3",    8, 0, 1, 0);

        // ABORT while DONE clears DONE and PASS.
        mode0 = 0; sweep0("nor3b", 0, 0, 0, 1);
        bus0.ABORT = 1'b1;
        cyc(1);
        bus0.ABORT = 1'b0;
        check("abort_done_done", bus0.DONE, 1'b0);
        check("abort_done_pass", bus0.PASS, 1'b0);

        // One-edge reset at e0+10.
        mode0 = 1;
        pulse_start0();
        cyc(9);
        rn = 1'b0;
        cyc(1);
        check("midrst_busy", bus0.BUSY,       1'b0);
        check("midrst_stim", bus0.STIM,       3'd0);
        check("midrst_err",  bus0.ERR_CNT,    4'd0);
        check("midrst_fv",   bus0.FAIL_VALID, 1'b0);
        check("midrst_ff",   bus0.FIRST_FAIL, 3'd0);
        rn = 1'b1;
        mode0 = 0; sweep0("after_rst", 0, 0, 0, 1);

        // ABORT at e0+7 with stuck-at-1: only vector 1 has been found bad.
        mode0 = 1;
        pulse_start0();
        cyc(6);
        bus0.ABORT = 1'b1;
        cyc(1);
        bus0.ABORT = 1'b0;
        check("abort_busy", bus0.BUSY,       1'b0);
        check("abort_done", bus0.DONE,       1'b0);
        check("abort_stim", bus0.STIM,       3'd0);
        check("abort_err",  bus0.ERR_CNT,    4'd1);
        check("abort_ff",   bus0.FIRST_FAIL, 3'd1);
        check("abort_fv",   bus0.FAIL_VALID, 1'b1);

        // START pulses during BUSY leave DONE timing untouched.
        mode0 = 0;
        pulse_start0();
        cyc(4);
        bus0.START = 1'b1; cyc(1); bus0.START = 1'b0;
        cyc(6);
        bus0.START = 1'b1; cyc(1); bus0.START = 1'b0;
        cyc(11);
        check("rest_done_early", bus0.DONE, 1'b0);
        cyc(1);
        check("rest_done", bus0.DONE, 1'b1);
        check("rest_pass", bus0.PASS, 1'b1);

        // START and ABORT together: no sweep begins.
        bus0.START = 1'b1; bus0.ABORT = 1'b1;
        cyc(1);
        bus0.START = 1'b0; bus0.ABORT = 1'b0;
        check("both_busy", bus0.BUSY, 1'b0);
        check("both_done", bus0.DONE, 1'b0);

        mode1 = 0; sweep1("nand2",    0, 0, 0, 1);
        mode1 = 1; sweep1("nand2_s0", 3, 0, 1, 0);

        // Random control traffic; the compare process checks dut0 every cycle.
        for (int i = 0; i < 1500; i++) begin
            bus0.START = ($urandom_range(0, 19) == 0);
            bus0.ABORT = ($urandom_range(0, 69) == 0);
            rn         = ($urandom_range(0, 249) != 0);
            if ($urandom_range(0, 29) == 0) mode0 = $urandom_range(0, 4);
            cyc(1);
        end
        bus0.START = 1'b0;
        bus0.ABORT = 1'b0;
        rn = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
